// File: rtl/riscv_trace_buffer.sv
// Execution-trace capture FIFO for the RISC-V core with end-of-program and watchdog freeze.
// Ports: clk/rst(async low), clear, trace_en, core taps in; FWFT read port, count and status out.
module riscv_trace_buffer #(
   parameter int unsigned     XLEN    = 32,
   parameter int unsigned     DEPTH   = 16,
   parameter logic [XLEN-1:0] END_PC  = XLEN'(32'h10),
   parameter int unsigned     TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     trace_en,
   input  logic [XLEN-1:0]          pc,
   input  logic [XLEN-1:0]          instruction,
   input  logic [XLEN-1:0]          alu_result,
   input  logic [XLEN-1:0]          rd1,
   input  logic [XLEN-1:0]          rd2,
   input  logic                     reg_write,
   input  logic                     alu_src,
   input  logic                     mem_write,
   input  logic                     mem_read,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [XLEN-1:0]          rd_pc,
   output logic [XLEN-1:0]          rd_inst,
   output logic [XLEN-1:0]          rd_alu,
   output logic [XLEN-1:0]          rd_rd1,
   output logic [XLEN-1:0]          rd_rd2,
   output logic [3:0]               rd_ctrl,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     halted,
   output logic                     timeout,
   output logic [31:0]              cycle_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_HALTED,
      S_TIMEOUT
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [3:0]      ctrl;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          head;
   state_e          state_q, state_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [AW:0]     count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [31:0]     cycle_q, cycle_d;
   logic [XLEN-1:0] last_pc_q, last_pc_d;
   logic            first_q, first_d;

   logic full, empty, pop, sample, end_hit, push, accept, we;

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      cycle_d    = cycle_q;
      last_pc_d  = last_pc_q;
      first_d    = first_q;

      full    = (count_q == (AW+1)'(DEPTH));
      empty   = (count_q == '0);
      pop     = rd_en && !empty;
      sample  = (state_q == S_CAPTURE) && trace_en;
      end_hit = (pc >= END_PC);
      // pc-change filter collapses stalls into a single entry
      push    = sample && !end_hit && (first_q || (pc != last_pc_q));
      // a pop in the same cycle frees the slot the push needs
      accept  = push && (!full || pop);
      we      = accept && !clear;

      if (sample) begin
         if (cycle_q != '1) cycle_d = cycle_q + 32'd1;
         if (end_hit) state_d = S_HALTED;
         else if (cycle_q == 32'(TIMEOUT - 1)) state_d = S_TIMEOUT;
      end

      if (accept) begin
         wptr_d    = wptr_q + AW'(1);
         last_pc_d = pc;
         first_d   = 1'b0;
      end
      if (pop) rptr_d = rptr_q + AW'(1);

      if (accept && !pop) count_d = count_q + (AW+1)'(1);
      else if (pop && !accept) count_d = count_q - (AW+1)'(1);

      if (push && full && !pop) overflow_d = 1'b1;

      if ((state_q == S_IDLE) && trace_en) begin
         state_d = S_CAPTURE;
         first_d = 1'b1;
      end

      if (clear) begin
         state_d    = S_IDLE;
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         cycle_d    = '0;
         first_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         cycle_q    <= '0;
         last_pc_q  <= '0;
         first_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         cycle_q    <= cycle_d;
         last_pc_q  <= last_pc_d;
         first_q    <= first_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wptr_q] <= '{pc:   pc,
                            inst: instruction,
                            alu:  alu_result,
                            rd1:  rd1,
                            rd2:  rd2,
                            ctrl: {reg_write, alu_src, mem_write, mem_read}};
      end
   end

   // empty FIFO reads as zero rather than stale slot contents
   assign head        = empty ? '0 : mem_q[rptr_q];
   assign rd_valid    = !empty;
   assign rd_pc       = head.pc;
   assign rd_inst     = head.inst;
   assign rd_alu      = head.alu;
   assign rd_rd1      = head.rd1;
   assign rd_rd2      = head.rd2;
   assign rd_ctrl     = head.ctrl;
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign halted      = (state_q == S_HALTED);
   assign timeout     = (state_q == S_TIMEOUT);
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer.
// Two instances: default parameters and a small DEPTH=4/END_PC=0x20/TIMEOUT=8 build.
module tb_riscv_trace_buffer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clear = 1'b0;
   logic trace_en = 1'b0;
   logic rd_en = 1'b0;
   logic [31:0] pc = '0, inst = '0, alu = '0, r1 = '0, r2 = '0;
   logic [3:0] ctrl = '0;

   logic v0, ov0, h0, t0;
   logic [31:0] pc0, in0, al0, a0, b0, cc0;
   logic [3:0] c0;
   logic [4:0] cnt0;

   logic v1, ov1, h1, t1;
   logic [31:0] pc1, in1, al1, a1, b1, cc1;
   logic [3:0] c1;
   logic [2:0] cnt1;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   riscv_trace_buffer u_dut0 (
      .clk(clk), .rst(rst), .clear(clear), .trace_en(trace_en),
      .pc(pc), .instruction(inst), .alu_result(alu), .rd1(r1), .rd2(r2),
      .reg_write(ctrl[3]), .alu_src(ctrl[2]),
      .mem_write(ctrl[1]), .mem_read(ctrl[0]),
      .rd_en(rd_en), .rd_valid(v0),
      .rd_pc(pc0), .rd_inst(in0), .rd_alu(al0), .rd_rd1(a0), .rd_rd2(b0),
      .rd_ctrl(c0), .count(cnt0), .overflow(ov0),
      .halted(h0), .timeout(t0), .cycle_count(cc0)
   );

   riscv_trace_buffer #(
      .XLEN(32), .DEPTH(4), .END_PC(32'h20), .TIMEOUT(8)
   ) u_dut1 (
      .clk(clk), .rst(rst), .clear(clear), .trace_en(trace_en),
      .pc(pc), .instruction(inst), .alu_result(alu), .rd1(r1), .rd2(r2),
      .reg_write(ctrl[3]), .alu_src(ctrl[2]),
      .mem_write(ctrl[1]), .mem_read(ctrl[0]),
      .rd_en(rd_en), .rd_valid(v1),
      .rd_pc(pc1), .rd_inst(in1), .rd_alu(al1), .rd_rd1(a1), .rd_rd2(b1),
      .rd_ctrl(c1), .count(cnt1), .overflow(ov1),
      .halted(h1), .timeout(t1), .cycle_count(cc1)
   );

   function automatic logic [31:0] f_inst(input logic [31:0] p);
      return 32'h1300_0000 | p;
   endfunction
   function automatic logic [31:0] f_alu(input logic [31:0] p);
      return p + 32'h100;
   endfunction
   function automatic logic [3:0] f_ctrl(input logic [31:0] p);
      return p[5:2] ^ 4'h5;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [31:0] p);
      pc   = p;
      inst = f_inst(p);
      alu  = f_alu(p);
      r1   = p ^ 32'hAA;
      r2   = ~p;
      ctrl = f_ctrl(p);
      tick();
   endtask

   task automatic start();
      trace_en = 1'b0;
      rd_en = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      trace_en = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) tick();
      total_cnt++; if (cnt0 !== 5'd0) $display("FAIL rst_count got %0d want 0", cnt0); else pass_cnt++;
      total_cnt++; if ({v0, ov0, h0, t0} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {v0, ov0, h0, t0}); else pass_cnt++;
      total_cnt++; if (cc0 !== 32'd0) $display("FAIL rst_cycles got %0d want 0", cc0); else pass_cnt++;
      total_cnt++; if (pc0 !== 32'd0) $display("FAIL rst_rd_pc got %h want 0", pc0); else pass_cnt++;
      total_cnt++; if ({v1, cnt1} !== 4'b0) $display("FAIL rst_dut1 got %b want 0000", {v1, cnt1}); else pass_cnt++;
      rst = 1'b1;
      tick();
      start();
      sample(32'h0);
      sample(32'h4);
      total_cnt++; if (cnt0 !== 5'd2) $display("FAIL rst_pre_count got %0d want 2", cnt0); else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++; if ({v0, cnt0} !== 6'd0) $display("FAIL rst_async got %b want 0", {v0, cnt0}); else pass_cnt++;
      total_cnt++; if ({pc0, cc0} !== 64'd0) $display("FAIL rst_async_data got %h want 0", {pc0, cc0}); else pass_cnt++;
      repeat (2) tick();
      rst = 1'b1;
      pc = 32'h8;
      tick();
      total_cnt++; if (cnt0 !== 5'd0) $display("FAIL rst_idle_nopush got %0d want 0", cnt0); else pass_cnt++;
   endtask

   task automatic test_program_end();
      logic [31:0] exp;
      start();
      for (int i = 0; i < 4; i++) sample(32'(i * 4));
      sample(32'h10);
      trace_en = 1'b0;
      total_cnt++; if (cnt0 !== 5'd4) $display("FAIL pe_count got %0d want 4", cnt0); else pass_cnt++;
      total_cnt++; if ({h0, t0} !== 2'b10) $display("FAIL pe_halted got %b want 10", {h0, t0}); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         exp = 32'(i * 4);
         total_cnt++; if ({v0, pc0} !== {1'b1, exp}) $display("FAIL pe_rd_pc%0d got %h want %h", i, pc0, exp); else pass_cnt++;
         total_cnt++; if ({in0, al0} !== {f_inst(exp), f_alu(exp)}) $display("FAIL pe_rd_data%0d got %h %h want %h %h", i, in0, al0, f_inst(exp), f_alu(exp)); else pass_cnt++;
         total_cnt++; if ({a0, b0, c0} !== {exp ^ 32'hAA, ~exp, f_ctrl(exp)}) $display("FAIL pe_rd_regs%0d got %h %h %h", i, a0, b0, c0); else pass_cnt++;
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
      total_cnt++; if ({v0, cnt0} !== 6'd0) $display("FAIL pe_empty got %b want 0", {v0, cnt0}); else pass_cnt++;
      total_cnt++; if (pc0 !== 32'd0) $display("FAIL pe_empty_pc got %h want 0", pc0); else pass_cnt++;
   endtask

   task automatic test_stall_filter();
      start();
      rd_en = 1'b1;
      sample(32'h4);
      rd_en = 1'b0;
      total_cnt++; if (cnt0 !== 5'd1) $display("FAIL st_pop_empty got %0d want 1", cnt0); else pass_cnt++;
      sample(32'h4);
      sample(32'h4);
      sample(32'h8);
      total_cnt++; if (cnt0 !== 5'd2) $display("FAIL st_count got %0d want 2", cnt0); else pass_cnt++;
      total_cnt++; if (cc0 !== 32'd4) $display("FAIL st_cycles got %0d want 4", cc0); else pass_cnt++;
      trace_en = 1'b0;
      tick();
      total_cnt++; if (cc0 !== 32'd4) $display("FAIL st_cycles_hold got %0d want 4", cc0); else pass_cnt++;
      total_cnt++; if (pc0 !== 32'h4) $display("FAIL st_head0 got %h want 4", pc0); else pass_cnt++;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      total_cnt++; if (pc0 !== 32'h8) $display("FAIL st_head1 got %h want 8", pc0); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      start();
      for (int i = 0; i < 4; i++) sample(32'(i * 4));
      total_cnt++; if ({cnt1, ov1} !== {3'd4, 1'b0}) $display("FAIL ov_full got %0d/%b want 4/0", cnt1, ov1); else pass_cnt++;
      sample(32'h0);
      trace_en = 1'b0;
      total_cnt++; if ({cnt1, ov1} !== {3'd4, 1'b1}) $display("FAIL ov_drop got %0d/%b want 4/1", cnt1, ov1); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         exp = 32'(i * 4);
         total_cnt++; if (pc1 !== exp) $display("FAIL ov_rd_pc%0d got %h want %h", i, pc1, exp); else pass_cnt++;
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
      total_cnt++; if (v1 !== 1'b0) $display("FAIL ov_empty got %b want 0", v1); else pass_cnt++;
   endtask

   task automatic test_full_pop();
      logic [31:0] exp;
      start();
      for (int i = 0; i < 4; i++) sample(32'(i * 4));
      rd_en = 1'b1;
      sample(32'h14);
      rd_en = 1'b0;
      trace_en = 1'b0;
      total_cnt++; if ({cnt1, ov1} !== {3'd4, 1'b0}) $display("FAIL fp_count got %0d/%b want 4/0", cnt1, ov1); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         exp = (i == 3) ? 32'h14 : 32'((i + 1) * 4);
         total_cnt++; if (pc1 !== exp) $display("FAIL fp_rd_pc%0d got %h want %h", i, pc1, exp); else pass_cnt++;
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
   endtask

   task automatic test_halt_priority();
      start();
      repeat (7) sample(32'h0);
      total_cnt++; if ({cc1, h1, t1} !== {32'd7, 2'b00}) $display("FAIL hp_pre got %0d %b%b want 7 00", cc1, h1, t1); else pass_cnt++;
      sample(32'h20);
      total_cnt++; if ({h1, t1, cnt1} !== {2'b10, 3'd1}) $display("FAIL hp_state got %b%b %0d want 10 1", h1, t1, cnt1); else pass_cnt++;
   endtask

   task automatic test_watchdog();
      start();
      repeat (7) sample(32'h0);
      total_cnt++; if (t1 !== 1'b0) $display("FAIL wd_early got %b want 0", t1); else pass_cnt++;
      sample(32'h0);
      total_cnt++; if ({t1, h1} !== 2'b10) $display("FAIL wd_fire got %b%b want 10", t1, h1); else pass_cnt++;
      total_cnt++; if ({cc1, cnt1} !== {32'd8, 3'd1}) $display("FAIL wd_counts got %0d %0d want 8 1", cc1, cnt1); else pass_cnt++;
      sample(32'h4);
      total_cnt++; if ({cc1, cnt1} !== {32'd8, 3'd1}) $display("FAIL wd_frozen got %0d %0d want 8 1", cc1, cnt1); else pass_cnt++;
      trace_en = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      total_cnt++; if ({v1, cnt1, ov1, h1, t1} !== 7'd0) $display("FAIL wd_clear got %b want 0", {v1, cnt1, ov1, h1, t1}); else pass_cnt++;
      total_cnt++; if (cc1 !== 32'd0) $display("FAIL wd_clear_cycles got %0d want 0", cc1); else pass_cnt++;
      trace_en = 1'b1;
      tick();
      total_cnt++; if (cnt1 !== 3'd0) $display("FAIL wd_idle got %0d want 0", cnt1); else pass_cnt++;
      sample(32'h4);
      total_cnt++; if ({cnt1, pc1} !== {3'd1, 32'h4}) $display("FAIL wd_restart got %0d %h want 1 4", cnt1, pc1); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_program_end();
      test_stall_filter();
      test_overflow();
      test_full_pop();
      test_halt_priority();
      test_watchdog();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Synthesizable execution-trace capture block for the RISC-V core, with parametrised width and depth. It samples the core's PC, instruction, ALU result, register read data and main control strobes into an on-chip FIFO. It detects end-of-program (PC at or beyond a programmable end address) and a stuck-core watchdog timeout, and freezes capture on either. Host logic or the bench drains entries through a first-word-fall-through read port.

## Interface
Parameters:
- XLEN, 32: width of pc, instruction, alu_result, rd1, rd2.
- DEPTH, 16: FIFO entries; power of two, ≥2.
- END_PC, 32'h10: a sampled pc ≥ END_PC ends the program.
- TIMEOUT, 1024: maximum number of CAPTURE cycles before the watchdog fires; ≥2.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous flush; returns to IDLE.
- trace_en  in  1  capture enable.
- pc, instruction, alu_result, rd1, rd2  in  XLEN each  core observation taps.
- reg_write, alu_src, mem_write, mem_read  in  1 each  core control taps.
- rd_en  in  1  pop head entry; ignored when rd_valid=0.
- rd_valid  out  1  FIFO non-empty.
- rd_pc, rd_inst, rd_alu, rd_rd1, rd_rd2  out  XLEN each  head entry fields.
- rd_ctrl  out  4  head entry {reg_write, alu_src, mem_write, mem_read}.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; an entry was dropped while full.
- halted  out  1  in HALTED state.
- timeout  out  1  in TIMEOUT state.
- cycle_count  out  32  CAPTURE cycles; saturates at all-ones.

## Operation
- States:
  - IDLE: waiting for trace_en. Go to CAPTURE on trace_en=1.
  - CAPTURE:
    - pc ≥ END_PC and trace_en=1: go to HALTED. The sample is not stored.
    - Else, cycle_count == TIMEOUT-1: go to TIMEOUT. The sample is still eligible for storage.
  - HALTED, TIMEOUT: terminal. No pushes occur; reads continue. Exit only via clear or rst.
- Halt has priority over timeout when both occur in the same cycle.
- Push condition: state CAPTURE, trace_en=1, pc < END_PC, and either first sample since entering CAPTURE or pc ≠ last stored pc.
  - The pc-change filter collapses core stalls to one entry.
- trace_en=0 while in CAPTURE: no push, cycle_count holds, state holds.
- cycle_count increments on every CAPTURE cycle with trace_en=1.
- FIFO:
  - Circular buffer with wrap-around read/write pointers; count tracks occupancy.
  - Full (count==DEPTH), push, no pop: entry dropped, overflow←1, count unchanged.
  - Full, push and pop in the same cycle: both accepted; count stays DEPTH; no overflow.
  - Empty, push and rd_en: push only; rd_en is ignored.
  - Dropped entries do not update the last-stored pc.
- clear: empties the FIFO and clears overflow, cycle_count, halted and timeout; state←IDLE. clear overrides any push or pop in that cycle.

## Timing
- Reset (rst=0, asynchronous) sets:
  - state=IDLE
  - count=0, rd_valid=0, overflow=0, halted=0, timeout=0, cycle_count=0
  - both FIFO pointers=0; rd_* fields read as 0 when empty.
- All inputs are sampled at the rising clk edge.
- A sample stored at edge N appears on rd_* and rd_valid after edge N, when it is the head: one-cycle latency.
- The read port is first-word-fall-through: rd_* is combinational from the head slot. A pop at edge N presents the next entry after edge N.
- The IDLE→CAPTURE transition takes effect at the edge where trace_en=1 is sampled. The first sample is taken at the following edge.
- halted/timeout assert after the edge at which the terminating condition is sampled.
- Reset asserted mid-capture aborts immediately; no partial entry survives.

## Test plan
- Reset: hold rst=0 for 2 cycles, mid-stream after traffic → every output 0, rd_valid=0, state IDLE.
- Program end: trace_en=1, pc 0,4,8,C,10 on consecutive cycles → count=4, halted=1 after the 0x10 edge; drain yields rd_pc 0,4,8,C in order with matching inst/alu/ctrl; rd_valid=0 afterwards.
- Stall filter: pc=4 held for 3 cycles, then 8 → exactly 2 entries (4, 8).
- Overflow: DEPTH=4, pc 0,4,8,C,0 (wrap of distinct values below END_PC=0x20), no reads → count=4, overflow=1, stored entries 0,4,8,C.
- Full with simultaneous pop: DEPTH=4 full, rd_en=1 while pushing pc=0x14 → count stays 4, overflow=0, tail=0x14, head advances by one.
- Watchdog: TIMEOUT=8, pc stuck at 0 → 1 entry, timeout=1 after the 8th CAPTURE cycle, cycle_count=8; then clear=1 → all status 0, IDLE.
